// File: rtl/lcd_mode_ctrl_pkg.sv
// Shared LCD timing constants and mode encoding for the mode sequencer and the pixel fetcher.
package lcd_pkg;

    localparam int LCD_DOTS_PER_LINE  = 456;
    localparam int LCD_OAM_DOTS       = 80;
    localparam int LCD_VISIBLE_LINES  = 144;
    localparam int LCD_TOTAL_LINES    = 154;
    localparam int LCD_LCD_WIDTH      = 160;
    localparam int LCD_LY153_ZERO_DOT = 4;

    typedef enum logic [1:0] {
        MODE_HBLANK = 2'd0,
        MODE_VBLANK = 2'd1,
        MODE_OAM    = 2'd2,
        MODE_XFER   = 2'd3
    } lcd_mode_t;

endpackage

// File: rtl/lcd_mode_ctrl_stat_irq.sv
// STAT interrupt line: masks the four sources, ORs them and pulses on a rising edge only,
// so a line that stays high across source changes raises no extra interrupt.
module lcd_stat_irq
    import lcd_pkg::*;
(
    input  logic       clock,
    input  logic       nreset,
    input  logic       lcd_en,
    input  lcd_mode_t  mode,
    input  logic       ly_eq,
    input  logic [3:0] src_en,
    output logic       stat_irq
);

    logic [2:0] mode_hit;
    logic       stat_line;
    logic       line_reg;
    logic       irq_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_mode_src
            assign mode_hit[gi] = src_en[gi] && (mode == 2'(gi));
        end
    endgenerate

    assign stat_line = (|mode_hit) || (ly_eq && src_en[3]);

    always_ff @(posedge clock) begin
        if (nreset || !lcd_en) begin
            line_reg <= 1'b0;
            irq_reg  <= 1'b0;
        end else begin
            line_reg <= stat_line;
            irq_reg  <= stat_line && !line_reg;
        end
    end

    assign stat_irq = irq_reg;

endmodule

// File: rtl/lcd_mode_ctrl.sv
// Per-dot LCD mode/line/dot sequencer with STAT/VBlank interrupts and CPU lock outputs.
// Optional LCD_LY153_EARLY_ZERO_EN: LY reads 0 from dot 4 of line 153.
module lcd_mode_ctrl
    import lcd_pkg::*;
#(
    parameter int DOTS_PER_LINE = LCD_DOTS_PER_LINE,
    parameter int OAM_DOTS      = LCD_OAM_DOTS,
    parameter int VISIBLE_LINES = LCD_VISIBLE_LINES,
    parameter int TOTAL_LINES   = LCD_TOTAL_LINES,
    parameter int LCD_WIDTH     = LCD_LCD_WIDTH
) (
    input  logic       clock,
    input  logic       nreset,
    input  logic       lcd_en,
    input  logic [7:0] lyc,
    input  logic [3:0] stat_src_en,
    input  logic       x_inc,
    output logic [1:0] mode_n,
    output logic [7:0] y_pos,
    output logic [7:0] x_pos,
    output logic [8:0] dot_count,
    output logic       ly_eq_lyc,
    output logic       stat_irq,
    output logic       vblank_irq,
    output logic       vram_lock,
    output logic       oam_lock
);

    localparam logic [8:0] LAST_DOT     = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] LAST_OAM_DOT = 9'(OAM_DOTS - 1);
    localparam logic [7:0] VBLANK_LINE  = 8'(VISIBLE_LINES);
    localparam logic [7:0] LAST_LINE    = 8'(TOTAL_LINES - 1);
    localparam logic [7:0] LAST_PIXEL   = 8'(LCD_WIDTH - 1);
    localparam logic [7:0] X_DONE       = 8'(LCD_WIDTH);

    lcd_mode_t  mode_reg, mode_next;
    logic [7:0] ly_reg, ly_next;
    logic [7:0] y_pos_reg, y_pos_next;
    logic [7:0] x_reg, x_next;
    logic [8:0] dot_reg, dot_next;
    logic       running_reg;
    logic       ly_eq_reg, ly_eq_next;
    logic       vblank_reg;
    logic       vram_lock_reg;
    logic       oam_lock_reg;

    always_comb begin
        mode_next = mode_reg;
        ly_next   = ly_reg;
        x_next    = x_reg;
        dot_next  = dot_reg + 9'd1;
        if (!running_reg) begin
            mode_next = MODE_OAM;
            ly_next   = 8'd0;
            x_next    = 8'd0;
            dot_next  = 9'd0;
        end else if (dot_reg == LAST_DOT) begin
            // Line end wins even over an unfinished mode 3.
            dot_next  = 9'd0;
            ly_next   = (ly_reg == LAST_LINE) ? 8'd0 : ly_reg + 8'd1;
            mode_next = (ly_next >= VBLANK_LINE) ? MODE_VBLANK : MODE_OAM;
            x_next    = 8'd0;
        end else if (mode_reg == MODE_OAM && dot_reg == LAST_OAM_DOT) begin
            mode_next = MODE_XFER;
            x_next    = 8'd0;
        end else if (mode_reg == MODE_XFER && x_inc) begin
            if (x_reg == LAST_PIXEL) begin
                mode_next = MODE_HBLANK;
                x_next    = X_DONE;
            end else begin
                x_next = x_reg + 8'd1;
            end
        end
    end

    always_comb begin
        y_pos_next = ly_next;
`ifdef LCD_LY153_EARLY_ZERO_EN
        if (ly_next == LAST_LINE && dot_next >= 9'(LCD_LY153_ZERO_DOT)) begin
            y_pos_next = 8'd0;
        end
`endif
    end

    assign ly_eq_next = (y_pos_reg == lyc);

    always_ff @(posedge clock) begin
        if (nreset || !lcd_en) begin
            running_reg   <= 1'b0;
            mode_reg      <= MODE_HBLANK;
            ly_reg        <= 8'd0;
            y_pos_reg     <= 8'd0;
            x_reg         <= 8'd0;
            dot_reg       <= 9'd0;
            ly_eq_reg     <= 1'b0;
            vblank_reg    <= 1'b0;
            vram_lock_reg <= 1'b0;
            oam_lock_reg  <= 1'b0;
        end else begin
            running_reg   <= 1'b1;
            mode_reg      <= mode_next;
            ly_reg        <= ly_next;
            y_pos_reg     <= y_pos_next;
            x_reg         <= x_next;
            dot_reg       <= dot_next;
            ly_eq_reg     <= ly_eq_next;
            vblank_reg    <= running_reg && ly_reg == VBLANK_LINE && dot_reg == 9'd0;
            vram_lock_reg <= (mode_next == MODE_XFER);
            oam_lock_reg  <= (mode_next == MODE_OAM) || (mode_next == MODE_XFER);
        end
    end

    // The mode term is taken one dot late so it lines up with the one-dot-late LYC compare;
    // otherwise the line would drop for a dot at each line start and break STAT blocking.
    lcd_stat_irq u_stat_irq (
        .clock    (clock),
        .nreset   (nreset),
        .lcd_en   (lcd_en),
        .mode     (mode_reg),
        .ly_eq    (ly_eq_next),
        .src_en   (stat_src_en),
        .stat_irq (stat_irq)
    );

    assign mode_n     = mode_reg;
    assign y_pos      = y_pos_reg;
    assign x_pos      = x_reg;
    assign dot_count  = dot_reg;
    assign ly_eq_lyc  = ly_eq_reg;
    assign vblank_irq = vblank_reg;
    assign vram_lock  = vram_lock_reg;
    assign oam_lock   = oam_lock_reg;

endmodule

// File: tb/tb_lcd_mode_ctrl.sv
// Randomized bench for lcd_mode_ctrl against a frame-position reference model.
// Honours LCD_LY153_EARLY_ZERO_EN for the line-153 expectations.
module tb_lcd_mode_ctrl;

    logic       clock = 1'b0;
    logic       nreset;
    logic       lcd_en;
    logic [7:0] lyc;
    logic [3:0] stat_src_en;
    logic       x_inc;
    logic [1:0] mode_n;
    logic [7:0] y_pos;
    logic [7:0] x_pos;
    logic [8:0] dot_count;
    logic       ly_eq_lyc;
    logic       stat_irq;
    logic       vblank_irq;
    logic       vram_lock;
    logic       oam_lock;

    always #5 clock = ~clock;

    lcd_mode_ctrl dut (
        .clock       (clock),
        .nreset      (nreset),
        .lcd_en      (lcd_en),
        .lyc         (lyc),
        .stat_src_en (stat_src_en),
        .x_inc       (x_inc),
        .mode_n      (mode_n),
        .y_pos       (y_pos),
        .x_pos       (x_pos),
        .dot_count   (dot_count),
        .ly_eq_lyc   (ly_eq_lyc),
        .stat_irq    (stat_irq),
        .vblank_irq  (vblank_irq),
        .vram_lock   (vram_lock),
        .oam_lock    (oam_lock)
    );

    localparam int LINE  = 456;
    localparam int FRAME = 154 * 456;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: position in frame plus pixels pushed on the current line.
    bit         m_run  = 0;
    int         m_t    = 0;
    int         m_pix  = 0;
    logic [1:0] m_mode = 2'd0;
    logic [7:0] m_y    = 8'd0;
    logic [7:0] m_x    = 8'd0;
    logic [8:0] m_dot  = 9'd0;
    bit         m_eq   = 0;
    bit         m_stat = 0;
    bit         m_vbl  = 0;
    bit         m_hist = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h cycle=%0d line=%0d dot=%0d",
                     tag, got, exp, cyc, m_t / LINE, m_t % LINE);
        end
    endtask

    task automatic model_update();
        int         ol, od, ln, dt;
        logic [1:0] om;
        logic [7:0] oy;
        bit         orun, line_s;
        ol = m_t / LINE; od = m_t % LINE; om = m_mode; oy = m_y; orun = m_run;
        if (nreset || !lcd_en) begin
            m_run = 0; m_t = 0; m_pix = 0; m_mode = 2'd0; m_y = 8'd0; m_x = 8'd0;
            m_dot = 9'd0; m_eq = 0; m_stat = 0; m_vbl = 0; m_hist = 0;
        end else begin
            if (!m_run) begin
                m_run = 1; m_t = 0; m_pix = 0;
            end else begin
                if (om == 2'd3 && x_inc) m_pix++;
                m_t = (m_t + 1) % FRAME;
                if (m_t % LINE == 0) m_pix = 0;
            end
            ln = m_t / LINE; dt = m_t % LINE;
            m_mode = (ln >= 144) ? 2'd1 : (dt < 80) ? 2'd2 : (m_pix < 160) ? 2'd3 : 2'd0;
            m_x    = (ln < 144 && dt >= 80) ? 8'(m_pix) : 8'd0;
            m_dot  = 9'(dt);
            m_y    = 8'(ln);
`ifdef LCD_LY153_EARLY_ZERO_EN
            if (ln == 153 && dt >= 4) m_y = 8'd0;
`endif
            m_vbl  = orun && ol == 144 && od == 0;
            m_eq   = (oy == lyc);
            line_s = (m_eq && stat_src_en[3]) || (om == 2'd2 && stat_src_en[2]) ||
                     (om == 2'd1 && stat_src_en[1]) || (om == 2'd0 && stat_src_en[0]);
            m_stat = line_s && !m_hist;
            m_hist = line_s;
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_update();
        #1;
        cyc++;
        check_eq("mode", 32'(mode_n), 32'(m_mode));
        check_eq("y_pos", 32'(y_pos), 32'(m_y));
        check_eq("x_pos", 32'(x_pos), 32'(m_x));
        check_eq("dot", 32'(dot_count), 32'(m_dot));
        check_eq("flags", 32'({ly_eq_lyc, stat_irq, vblank_irq, vram_lock, oam_lock}),
                 32'({m_eq, m_stat, m_vbl, m_mode == 2'd3, m_mode == 2'd2 || m_mode == 2'd3}));
    endtask

    task automatic drive_inputs();
        int ln, dt;
        ln = m_t / LINE; dt = m_t % LINE;
        if (ln <= 2) x_inc = 1'b1;
        else if (ln == 5 || ln == 20) x_inc = 1'b0;
        else x_inc = ($urandom_range(0, 3) != 0);
        if (ln >= 8 && ln <= 10) begin
            lyc = 8'd10; stat_src_en = 4'b1001;
        end else if (ln >= 11 && ln <= 13) begin
            lyc = 8'd12; stat_src_en = 4'b1000;
        end else if (ln >= 147) begin
            lyc = 8'd0; stat_src_en = 4'b1000;
        end else if (dt == 0) begin
            lyc = 8'($urandom_range(0, 153)); stat_src_en = 4'($urandom_range(0, 15));
        end
    endtask

    initial begin
        int k, ln, dt, guard;
        int vbl_cnt, l5_m0, l10_stat, l12_stat, l12_dot, l153_stat;
        vbl_cnt = 0; l5_m0 = 0; l10_stat = 0; l12_stat = 0; l12_dot = -1; l153_stat = 0;
        nreset = 1'b1; lcd_en = 1'b1; lyc = 8'd0; stat_src_en = 4'd0; x_inc = 1'b0;

        $display("phase reset: nreset held 3 cycles");
        repeat (3) step();
        nreset = 1'b0;

        $display("phase run: line 0 to line 20 mode 3, then lcd_en drop");
        guard = 0;
        while (m_t != 20 * LINE + 100 && guard < 20000 && failures < 30) begin
            drive_inputs();
            step();
            guard++;
        end
        check_eq("reach_line20", 32'(y_pos), 32'd20);
        check_eq("line20_vram_lock", 32'(vram_lock), 32'd1);
        drive_inputs();
        lcd_en = 1'b0;
        step();
        check_eq("dis_mode", 32'(mode_n), 32'd0);
        check_eq("dis_y", 32'(y_pos), 32'd0);
        check_eq("dis_locks", 32'({vram_lock, oam_lock}), 32'd0);
        repeat (4) step();

        $display("phase reenable: full frame plus 3 lines");
        lcd_en = 1'b1;
        step();
        check_eq("reen_mode", 32'(mode_n), 32'd2);
        check_eq("reen_pos", 32'({y_pos, dot_count}), 32'd0);
        for (k = 1; k <= FRAME + 3 * LINE + 200 && failures < 30; k++) begin
            drive_inputs();
            step();
            ln = m_t / LINE; dt = m_t % LINE;
            if (vblank_irq) vbl_cnt++;
            if (ln == 5 && k < FRAME && mode_n == 2'd0) l5_m0++;
            if (ln == 5 && dt == 455 && k < FRAME) check_eq("l5_end_mode", 32'(mode_n), 32'd3);
            if (ln == 6 && dt == 0 && k < FRAME)
                check_eq("l6_start", 32'({mode_n, y_pos, x_pos}), 32'({2'd2, 8'd6, 8'd0}));
            if (stat_irq && k < FRAME) begin
                if (ln == 10) l10_stat++;
                if (ln == 12) begin l12_stat++; l12_dot = dt; end
                if (ln == 153) l153_stat++;
            end
            if (k == FRAME) check_eq("wrap", 32'({mode_n, y_pos, dot_count}), 32'({2'd2, 8'd0, 9'd0}));
        end
        check_eq("vblank_count", 32'(vbl_cnt), 32'd1);
        check_eq("l5_no_mode0", 32'(l5_m0), 32'd0);
        check_eq("l10_stat_blocked", 32'(l10_stat), 32'd0);
        check_eq("l12_stat_count", 32'(l12_stat), 32'd1);
        check_eq("l12_stat_dot", 32'(l12_dot), 32'd1);
`ifdef LCD_LY153_EARLY_ZERO_EN
        check_eq("l153_stat", 32'(l153_stat), 32'd1);
`else
        check_eq("l153_stat", 32'(l153_stat), 32'd0);
`endif

        $display("phase midframe reset: nreset asserted at line %0d dot %0d", m_t / LINE, m_t % LINE);
        nreset = 1'b1;
        step();
        check_eq("rst_mode", 32'(mode_n), 32'd0);
        check_eq("rst_y", 32'(y_pos), 32'd0);
        check_eq("rst_locks", 32'({vram_lock, oam_lock}), 32'd0);
        repeat (2) step();
        nreset = 1'b0;
        for (k = 0; k < 500 && failures < 30; k++) begin
            drive_inputs();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
